// File: rtl/cmd_seq_player_if.sv
// -----------------------------------------------------------------------------
// cmd_seq_player_if
// Link between the command-sequence player and RemoteComm.
//   cmd      : command word presented to RemoteComm (held between sends)
//   snd_cmd  : one-cycle strobe, cmd is valid in the same cycle
//   cmd_snt  : RemoteComm finished transmitting the last command
//   resp_rdy : response available (level; the player acts on its rising edge)
//   resp     : response byte, valid while resp_rdy is high
// Handshake semantics: snd_cmd is a single-cycle send request with no ready
// back-pressure; cmd_snt is a single-cycle completion event; a response is
// consumed on the cycle resp_rdy goes from 0 to 1, with resp sampled there.
// Modports: master = player side, slave = RemoteComm side.
// -----------------------------------------------------------------------------
interface cmd_seq_player_if #(
  parameter int CMD_W  = 16,
  parameter int RESP_W = 8
);
  logic [CMD_W-1:0]  cmd;
  logic              snd_cmd;
  logic              cmd_snt;
  logic              resp_rdy;
  logic [RESP_W-1:0] resp;

  modport master (output cmd, output snd_cmd, input cmd_snt, input resp_rdy, input resp);
  modport slave  (input cmd, input snd_cmd, output cmd_snt, output resp_rdy, output resp);
endinterface

// File: rtl/cmd_seq_player.sv
// -----------------------------------------------------------------------------
// cmd_seq_player
// Plays a programmable list of up to DEPTH commands to RemoteComm, one at a
// time, waiting for an acknowledge response after each with a per-command
// timeout. Reports pass count, error code and failing index.
//
// Optional feature macro: CMDSEQ_RETRY_EN -- when defined, the first timeout
// of a command re-issues that command once before reporting a timeout error.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   clr             : empty the command list (ignored while busy)
//   wr_en, wr_data  : append a command (dropped when full or busy)
//   full            : list holds DEPTH entries
//   start, abort    : begin playback from index 0 / stop playback
//   timeout_cycles  : per-command timeout, sampled on start (0 = disabled)
//   link            : RemoteComm handshake (cmd, snd_cmd, cmd_snt, resp_rdy, resp)
//   busy, done      : playback in progress / one-cycle end-of-run pulse
//   err, err_code   : sticky failure flag; 0 none, 1 bad resp, 2 timeout, 3 abort
//   err_idx         : index of the failing command
//   cnt_ok          : commands acknowledged in the last run
//   dbg_state       : current FSM state encoding
// -----------------------------------------------------------------------------
module cmd_seq_player #(
  parameter int                DEPTH  = 8,
  parameter int                CMD_W  = 16,
  parameter int                RESP_W = 8,
  parameter int                TO_W   = 22,
  parameter logic [RESP_W-1:0] ACK    = 8'hA5,
  localparam int               IW     = $clog2(DEPTH),
  localparam int               CW     = IW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [CMD_W-1:0] wr_data,
  output logic             full,
  input  logic             start,
  input  logic             abort,
  input  logic [TO_W-1:0]  timeout_cycles,
  cmd_seq_player_if.master link,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [IW-1:0]    err_idx,
  output logic [CW-1:0]    cnt_ok,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_SNT, WAIT_RESP, FIN} state_t;

  state_t            state_q, state_d;
  logic [CMD_W-1:0]  list_q [DEPTH];
  logic [CW-1:0]     n_q;
  logic [IW-1:0]     idx_q;
  logic [IW-1:0]     idx_inc;
  logic [TO_W-1:0]   to_lat_q, to_cnt_q;
  logic [CMD_W-1:0]  cmd_q;
  logic              resp_rdy_q;
  logic              wr_ok, last, resp_edge, to_hit, to_evt;
  logic              go, go_empty, ack_ok, fail;
  logic [1:0]        fail_code;
`ifdef CMDSEQ_RETRY_EN
  logic              retried_q, retry;
`endif

  assign full      = (n_q == CW'(DEPTH));
  assign busy      = (state_q == SEND) || (state_q == WAIT_SNT) || (state_q == WAIT_RESP);
  assign done      = (state_q == FIN);
  assign dbg_state = state_q;
  assign link.snd_cmd = (state_q == SEND);
  assign link.cmd     = cmd_q;

  assign wr_ok     = wr_en && !busy && !full && !clr;
  assign last      = ({1'b0, idx_q} == (n_q - 1'b1));
  assign idx_inc   = idx_q + 1'b1;
  assign resp_edge = link.resp_rdy && !resp_rdy_q;
  assign to_hit    = (to_lat_q != '0) && (to_cnt_q == to_lat_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    go        = 1'b0;
    go_empty  = 1'b0;
    ack_ok    = 1'b0;
    fail      = 1'b0;
    fail_code = 2'd0;
    to_evt    = 1'b0;
`ifdef CMDSEQ_RETRY_EN
    retry     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (n_q != '0) begin
            go      = 1'b1;
            state_d = SEND;
          end else begin
            go_empty = 1'b1;
            state_d  = FIN;
          end
        end
      end
      SEND:     state_d = WAIT_SNT;
      WAIT_SNT: begin
        if (to_hit)            to_evt  = 1'b1;
        else if (link.cmd_snt) state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        // A response edge in the expiry cycle wins over the timeout.
        if (resp_edge) begin
          if (link.resp == ACK) begin
            ack_ok  = 1'b1;
            state_d = last ? FIN : SEND;
          end else begin
            fail      = 1'b1;
            fail_code = 2'd1;
            state_d   = FIN;
          end
        end else if (to_hit) begin
          to_evt = 1'b1;
        end
      end
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    if (to_evt) begin
`ifdef CMDSEQ_RETRY_EN
      if (!retried_q) begin
        retry   = 1'b1;
        state_d = SEND;
      end else begin
        fail      = 1'b1;
        fail_code = 2'd2;
        state_d   = FIN;
      end
`else
      fail      = 1'b1;
      fail_code = 2'd2;
      state_d   = FIN;
`endif
    end

    // Abort overrides everything while a run is active; FIN is already
    // ending the run, so the reported result is left untouched there.
    if (abort && busy) begin
      ack_ok    = 1'b0;
      fail      = 1'b1;
      fail_code = 2'd3;
      state_d   = FIN;
`ifdef CMDSEQ_RETRY_EN
      retry     = 1'b0;
`endif
    end
  end

  // List contents need no reset: only entries below n_q are ever read.
  always_ff @(posedge clk) begin
    if (wr_ok) list_q[n_q[IW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q        <= '0;
      idx_q      <= '0;
      to_lat_q   <= '0;
      to_cnt_q   <= '0;
      cmd_q      <= '0;
      resp_rdy_q <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'd0;
      err_idx    <= '0;
      cnt_ok     <= '0;
    end else begin
      resp_rdy_q <= link.resp_rdy;

      if (clr && !busy) n_q <= '0;
      else if (wr_ok)   n_q <= n_q + 1'b1;

      if (state_q == SEND)
        to_cnt_q <= '0;
      else if (state_q == WAIT_SNT || state_q == WAIT_RESP)
        to_cnt_q <= to_cnt_q + 1'b1;

      // cmd is loaded on the transition into SEND so it is valid with the
      // strobe; a retry leaves it unchanged.
      if (go) begin
        err      <= 1'b0;
        err_code <= 2'd0;
        cnt_ok   <= '0;
        idx_q    <= '0;
        to_lat_q <= timeout_cycles;
        cmd_q    <= list_q[0];
      end
      if (go_empty) begin
        err      <= 1'b0;
        err_code <= 2'd0;
        cnt_ok   <= '0;
      end
      if (ack_ok) begin
        cnt_ok <= cnt_ok + 1'b1;
        if (!last) begin
          idx_q <= idx_inc;
          cmd_q <= list_q[idx_inc];
        end
      end
      if (fail) begin
        err      <= 1'b1;
        err_code <= fail_code;
        err_idx  <= idx_q;
      end
    end
  end

`ifdef CMDSEQ_RETRY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              retried_q <= 1'b0;
    else if (go || ack_ok)   retried_q <= 1'b0;
    else if (retry)          retried_q <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_cmd_seq_player.sv
// -----------------------------------------------------------------------------
// tb_cmd_seq_player
// Directed bench for cmd_seq_player with a RemoteComm stub. The stub answers
// each snd_cmd with cmd_snt two cycles later and, when enabled, a one-cycle
// resp_rdy pulse stub_delay cycles after cmd_snt, taking bytes from resp_tab.
// Commands seen on snd_cmd are checked against exp_q.
// -----------------------------------------------------------------------------
module tb_cmd_seq_player;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0, wr_en = 1'b0, start = 1'b0, abort = 1'b0;
  logic [15:0] wr_data = '0;
  logic [21:0] timeout_cycles = '0;
  logic        full, busy, done, err;
  logic [1:0]  err_code;
  logic [2:0]  err_idx;
  logic [3:0]  cnt_ok;
  logic [2:0]  dbg_state;

  cmd_seq_player_if #(.CMD_W(16), .RESP_W(8)) link ();

  cmd_seq_player dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .start(start), .abort(abort), .timeout_cycles(timeout_cycles),
    .link(link), .busy(busy), .done(done), .err(err), .err_code(err_code),
    .err_idx(err_idx), .cnt_ok(cnt_ok), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_cmp = 0, n_bad = 0;
  logic [15:0] exp_q[$];
  int snd_cnt = 0;
  int snd_cyc [16];
  int st_cyc, done_cyc, ab_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && link.snd_cmd) begin
      if (exp_q.size() == 0) check("snd_extra", 32'd1, 32'd0);
      else                   check("snd_cmd_val", {16'h0, link.cmd}, {16'h0, exp_q.pop_front()});
      if (snd_cnt < 16) snd_cyc[snd_cnt] = cyc;
      snd_cnt++;
    end
  end

  // ---------------- RemoteComm stub ----------------
  bit         stub_en = 1'b1;
  int         stub_delay = 50;
  logic [7:0] resp_tab [16];
  int         resp_k = 0;
  int         resp_cyc [16];

  initial begin
    link.cmd_snt  = 1'b0;
    link.resp_rdy = 1'b0;
    link.resp     = '0;
    forever begin
      @(negedge clk);
      if (rst_n && link.snd_cmd) begin
        int k;
        k = resp_k;
        resp_k++;
        repeat (2) @(posedge clk);
        #1 link.cmd_snt = 1'b1;
        @(posedge clk);
        #1 link.cmd_snt = 1'b0;
        if (stub_en) begin
          repeat (stub_delay - 1) @(posedge clk);
          #1;
          link.resp     = resp_tab[k % 16];
          link.resp_rdy = 1'b1;
          resp_cyc[k % 16] = cyc;
          @(posedge clk);
          #1 link.resp_rdy = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] d);
    tick();
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_clr();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic do_start(input logic [21:0] t);
    tick();
    timeout_cycles = t;
    start  = 1'b1;
    st_cyc = cyc;
    snd_cnt = 0;
    resp_k  = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        done_cyc = cyc;
        check("busy_at_done", {31'h0, busy}, 32'd0);
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic settle();
    repeat (150) tick();
    check("exp_left", exp_q.size(), 32'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    for (int i = 0; i < 16; i++) resp_tab[i] = 8'hA5;
    #23;
    check("rst_busy",  {31'h0, busy}, 32'd0);
    check("rst_outs",  {16'h0, link.cmd, 3'h0, link.snd_cmd, done, err, err_code, err_idx, cnt_ok},
                       32'd0);
    check("rst_state", {29'h0, dbg_state}, 32'd0);
    rst_n = 1'b1;

    // 1: two commands, all acknowledged after 50 cycles
    stub_en = 1'b1; stub_delay = 50;
    load(16'h0000); load(16'h23FF);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h23FF);
    do_start(22'd1000);
    wait_done(3000);
    check("t1_start_lat", snd_cyc[0], st_cyc + 1);
    check("t1_ack_to_snd", snd_cyc[1], resp_cyc[0] + 1);
    check("t1_ack_to_done", done_cyc, resp_cyc[1] + 1);
    check("t1_err", {31'h0, err}, 32'd0);
    check("t1_code", {30'h0, err_code}, 32'd0);
    check("t1_cnt_ok", {28'h0, cnt_ok}, 32'd2);
    settle();
    check("t1_snd_cnt", snd_cnt, 32'd2);

    // 2: bad response on the second of three commands
    do_clr();
    load(16'h1001); load(16'h1002); load(16'h1003);
    resp_tab[1] = 8'h5A;
    exp_q.push_back(16'h1001); exp_q.push_back(16'h1002);
    do_start(22'd1000);
    wait_done(3000);
    check("t2_err", {31'h0, err}, 32'd1);
    check("t2_code", {30'h0, err_code}, 32'd1);
    check("t2_idx", {29'h0, err_idx}, 32'd1);
    check("t2_cnt_ok", {28'h0, cnt_ok}, 32'd1);
    settle();
    check("t2_snd_cnt", snd_cnt, 32'd2);
    resp_tab[1] = 8'hA5;

    // 3: clr wins over wr_en; start on an empty list ends at once without error
    tick();
    clr = 1'b1; wr_en = 1'b1; wr_data = 16'h7777;
    tick();
    clr = 1'b0; wr_en = 1'b0;
    do_start(22'd10);
    wait_done(5);
    check("t3_empty_done", done_cyc, st_cyc + 1);
    check("t3_err", {31'h0, err}, 32'd0);
    check("t3_code", {30'h0, err_code}, 32'd0);
    settle();
    check("t3_snd_cnt", snd_cnt, 32'd0);

    // 4: no response, timeout 100
    stub_en = 1'b0;
    load(16'hCAFE);
    exp_q.push_back(16'hCAFE);
`ifdef CMDSEQ_RETRY_EN
    exp_q.push_back(16'hCAFE);
`endif
    do_start(22'd100);
    wait_done(1000);
    check("t4_err", {31'h0, err}, 32'd1);
    check("t4_code", {30'h0, err_code}, 32'd2);
    check("t4_idx", {29'h0, err_idx}, 32'd0);
`ifdef CMDSEQ_RETRY_EN
    check("t4_retry_gap", snd_cyc[1] - snd_cyc[0], 32'd102);
    check("t4_to_lat", done_cyc - snd_cyc[1], 32'd102);
    settle();
    check("t4_snd_cnt", snd_cnt, 32'd2);
`else
    check("t4_to_lat", done_cyc - snd_cyc[0], 32'd102);
    settle();
    check("t4_snd_cnt", snd_cnt, 32'd1);
`endif

    // 5: fill to DEPTH, ninth write dropped, timeout disabled, replay all
    do_clr();
    stub_en = 1'b1; stub_delay = 5;
    for (int i = 0; i < 7; i++) load(16'h0A00 + 16'(i));
    check("t5_not_full7", {31'h0, full}, 32'd0);
    load(16'h0A07);
    check("t5_full8", {31'h0, full}, 32'd1);
    load(16'h9999);
    check("t5_full9", {31'h0, full}, 32'd1);
    for (int i = 0; i < 8; i++) exp_q.push_back(16'h0A00 + 16'(i));
    do_start(22'd0);
    wait_done(3000);
    check("t5_err", {31'h0, err}, 32'd0);
    check("t5_cnt_ok", {28'h0, cnt_ok}, 32'd8);
    settle();
    check("t5_snd_cnt", snd_cnt, 32'd8);

    // 6: abort during WAIT_RESP
    do_clr();
    stub_en = 1'b0;
    load(16'h0AB0);
    exp_q.push_back(16'h0AB0);
    do_start(22'd0);
    repeat (5) tick();
    check("t6_in_wait_resp", {29'h0, dbg_state}, 32'd3);
    abort = 1'b1; ab_cyc = cyc;
    tick();
    abort = 1'b0;
    wait_done(5);
    check("t6_done_lat", done_cyc, ab_cyc + 1);
    check("t6_code", {30'h0, err_code}, 32'd3);
    check("t6_err", {31'h0, err}, 32'd1);
    settle();

    // 7: resp edge in the expiry cycle is accepted; one cycle later times out
    do_clr();
    stub_en = 1'b1; stub_delay = 59;
    load(16'h1111); load(16'h2222);
    exp_q.push_back(16'h1111); exp_q.push_back(16'h2222);
    do_start(22'd60);
    wait_done(1000);
    check("t7_err", {31'h0, err}, 32'd0);
    check("t7_cnt_ok", {28'h0, cnt_ok}, 32'd2);
    settle();
    stub_delay = 60;
    exp_q.push_back(16'h1111);
`ifdef CMDSEQ_RETRY_EN
    exp_q.push_back(16'h1111);
`endif
    do_start(22'd60);
    wait_done(1000);
    check("t7_late_code", {30'h0, err_code}, 32'd2);
    check("t7_late_idx", {29'h0, err_idx}, 32'd0);
    settle();

    // 8: asynchronous reset mid-run, then list count is zero
    do_clr();
    stub_en = 1'b1; stub_delay = 5;
    load(16'hBEEF); load(16'h1234);
    exp_q.push_back(16'hBEEF); exp_q.push_back(16'h1234);
    do_start(22'd0);
    repeat (10) tick();
    check("t8_pre_busy", {31'h0, busy}, 32'd1);
    check("t8_pre_cnt", {28'h0, cnt_ok}, 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t8_rst_busy", {31'h0, busy}, 32'd0);
    check("t8_rst_outs", {16'h0, link.cmd, 3'h0, link.snd_cmd, done, err, err_code, err_idx, cnt_ok},
                         32'd0);
    check("t8_rst_full_state", {28'h0, full, dbg_state}, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (30) tick();
    do_start(22'd0);
    wait_done(5);
    check("t8_empty_done", done_cyc, st_cyc + 1);
    settle();
    check("t8_snd_cnt", snd_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
